// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
// Show-ahead FIFO controller that uses one 1rw/1r1w-style SRAM macro
// (write port 0, read port 1) as 32-entry backing storage. A two-entry
// output buffer absorbs the macro's one-cycle read latency so that the
// consumer sees a word on pop_data in the same cycle pop_valid rises and
// both push and pop can sustain one word per clock.
//
// Occupancy accounting:
//   mem_cnt  words written to the macro but not yet read out
//   rd_pend  one macro read in flight (data arrives next edge)
//   ob_cnt   words held in the output buffer, ob[0] is the head
// The read-issue rule keeps ob_cnt + rd_pend <= 2, so a returning read
// always has a free output-buffer slot to land in.

module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 22,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  // producer side
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,

  // consumer side
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,

  // total words held (macro + in-flight read + output buffer)
  output logic [ADDR_WIDTH:0]   count,

  // macro write port 0
  output logic                  csb0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,

  // macro read port 1
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  // Pointers carry one extra wrap bit so that full (difference == DEPTH)
  // and empty (difference == 0) are distinguishable.
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam int OB_SLOTS = 2;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [PW-1:0]                      wptr_reg;
  logic [PW-1:0]                      wptr_next;
  logic [PW-1:0]                      rptr_reg;
  logic [PW-1:0]                      rptr_next;
  logic                               rd_pend_reg;
  logic                               rd_pend_next;
  logic [1:0]                         ob_cnt_reg;
  logic [1:0]                         ob_cnt_next;
  logic [OB_SLOTS-1:0][DATA_WIDTH-1:0] ob_reg;
  logic [OB_SLOTS-1:0][DATA_WIDTH-1:0] ob_next;

  // ------------------------------------------------------------------
  // Per-cycle decisions
  // ------------------------------------------------------------------
  logic [PW-1:0] mem_cnt;     // words resident in the macro
  logic          push_fire;
  logic          pop_fire;
  logic          rd_issue;
  logic [1:0]    ob_kept;     // buffer words left after this cycle's pop
  logic [1:0]    ob_occ;      // buffer words + in-flight read after the pop

  // Handshakes and read-issue decision, all from registered state plus
  // the current-cycle valid/ready inputs.
  always_comb begin
    mem_cnt    = wptr_reg - rptr_reg;

    // push_ready never looks at pop_ready: a full FIFO refuses the push
    // even if a pop frees a slot in the same cycle.
    push_ready = !rst && (mem_cnt != DEPTH_P);
    push_fire  = push_valid && push_ready;

    pop_valid  = (ob_cnt_reg != 2'd0);
    pop_fire   = pop_valid && pop_ready;

    // pop_fire implies ob_cnt_reg >= 1, so this cannot underflow.
    ob_kept    = ob_cnt_reg - {1'b0, pop_fire};
    ob_occ     = ob_kept + {1'b0, rd_pend_reg};

    // Only read when the returning word is guaranteed a buffer slot.
    // mem_cnt is built from the registered wptr, so a word written this
    // cycle is never read back in the same cycle.
    rd_issue   = !rst && (mem_cnt != '0) && (ob_occ < 2'd2);
  end

  // Next-state for pointers and counters.
  always_comb begin
    wptr_next    = wptr_reg + PW'(push_fire);
    rptr_next    = rptr_reg + PW'(rd_issue);
    rd_pend_next = rd_issue;
    // A pending read always lands, so occupancy after this edge is the
    // kept words plus the word arriving from the macro.
    ob_cnt_next  = ob_occ;
  end

  // ------------------------------------------------------------------
  // Output buffer slot update: shift on pop first, then drop the
  // returning macro word into the first free slot.
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < OB_SLOTS; gi++) begin : g_ob
      logic [DATA_WIDTH-1:0] shifted;

      if (gi < OB_SLOTS - 1) begin : g_shift
        assign shifted = pop_fire ? ob_reg[gi+1] : ob_reg[gi];
      end else begin : g_tail
        // The tail slot keeps its old value; after a pop it is simply
        // outside ob_cnt and is overwritten by the next capture.
        assign shifted = ob_reg[gi];
      end

      assign ob_next[gi] = (rd_pend_reg && (ob_kept == 2'(gi))) ? dout1 : shifted;
    end
  endgenerate

  // State registers; reset abandons any in-flight read and leaves the
  // macro contents stale but unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      rd_pend_reg <= 1'b0;
      ob_cnt_reg  <= 2'd0;
      ob_reg      <= '0;
    end else begin
      wptr_reg    <= wptr_next;
      rptr_reg    <= rptr_next;
      rd_pend_reg <= rd_pend_next;
      ob_cnt_reg  <= ob_cnt_next;
      ob_reg      <= ob_next;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // Macro port drive; address and data follow the pointers even when the
  // chip selects are idle, which keeps the port logic free of muxes.
  always_comb begin
    csb0  = !push_fire;
    addr0 = wptr_reg[ADDR_WIDTH-1:0];
    din0  = push_data;

    csb1  = !rd_issue;
    addr1 = rptr_reg[ADDR_WIDTH-1:0];
  end

  // Consumer view and total occupancy.
  always_comb begin
    pop_data = ob_reg[0];
    count    = mem_cnt + PW'(rd_pend_reg) + PW'(ob_cnt_reg);
  end

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Show-ahead FIFO controller that sequences one `sram_0rw1r1w_22_32_freepdk45` macro as 32-entry FIFO storage. Write port 0 carries pushes and read port 1 carries prefetch reads. A 2-entry output buffer hides the macro's read latency, so pushes and pops can each sustain one word per cycle. The block sits between a producer and a consumer; both macro clocks (`clk0`, `clk1`) are tied to `clk` at the parent level.

## Interface
- `DATA_WIDTH`, 22, word width; must match macro.
- `ADDR_WIDTH`, 5, macro address width.
- `DEPTH`, `1 << ADDR_WIDTH`, macro words. Total FIFO capacity is `DEPTH+2`.
- Clocking and reset (decided): one clock `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  clock; rising edge samples everything.
- `rst`  in  1  synchronous active-high reset.
- `push_valid`  in  1  producer has a word.
- `push_ready`  out  1  controller accepts a word this cycle.
- `push_data`  in  DATA_WIDTH  word to enqueue.
- `pop_valid`  out  1  head word available.
- `pop_ready`  in  1  consumer takes the head word.
- `pop_data`  out  DATA_WIDTH  head word.
- `count`  out  ADDR_WIDTH+1  total words held (SRAM + in-flight + output buffer).
- `csb0`  out  1  macro write-port select, active low.
- `addr0`  out  ADDR_WIDTH  macro write address.
- `din0`  out  DATA_WIDTH  macro write data.
- `csb1`  out  1  macro read-port select, active low.
- `addr1`  out  ADDR_WIDTH  macro read address.
- `dout1`  in  DATA_WIDTH  macro read data.

## Operation
- State registers:
  - `wptr`, `rptr`: ADDR_WIDTH+1 bits each, MSB is the wrap bit.
  - `mem_cnt = wptr - rptr`, range 0..DEPTH.
  - `rd_pend`: a macro read is in flight.
  - `ob[0:1]`: output buffer; `ob_cnt` 0..2; `ob[0]` is the head.
- Push fire = `push_valid && push_ready`.
  - `push_ready = !rst && mem_cnt != DEPTH`. It depends only on registered state, never on `pop_ready`.
  - On fire: `csb0=0`, `addr0=wptr[ADDR_WIDTH-1:0]`, `din0=push_data`; `wptr` increments at the clock edge.
- Pop fire = `pop_valid && pop_ready`.
  - `pop_valid = ob_cnt != 0`; `pop_data = ob[0]`.
  - On fire: `ob[1]` shifts to `ob[0]`.
- Read issue, decided combinationally each cycle:
  - Issue when `mem_cnt != 0 && (ob_cnt + rd_pend - pop_fire) < 2`.
  - On issue: `csb1=0`, `addr1=rptr[ADDR_WIDTH-1:0]`; `rptr` increments; `rd_pend` is set next cycle.
  - `mem_cnt` uses registered `wptr`, so a word pushed in cycle N is never read before cycle N+1. The macro therefore never sees the same address written and read in one cycle.
- Capture: in a cycle with `rd_pend=1`, `dout1` is written into the first free `ob` slot at the clock edge, after the pop shift is applied. `rd_pend` clears unless a new read issues.
- When idle: `csb0=csb1=1`; addr/data outputs still follow `wptr`, `rptr` and `push_data`.
- Wrap-around: pointers wrap naturally modulo `2*DEPTH`; full/empty is decided by the MSB-inclusive difference.
- `count = mem_cnt + rd_pend + ob_cnt`, maximum DEPTH+2.
- Reset (including mid-operation):
  - Clears `wptr`, `rptr`, `rd_pend`, `ob_cnt`, `ob[*]`.
  - Forces `csb0=csb1=1` while `rst` is high.
  - Data of an in-flight macro read is discarded; SRAM contents are left stale and unreachable.

## Timing
- Values during and after reset: `push_ready=0` while `rst=1`, and 1 in the first cycle after. `pop_valid=0`, `pop_data=0`, `count=0`, `csb0=csb1=1`.
- Macro write: registered at the next edge, committed at that cycle's falling edge.
- Macro read issued in cycle M: data valid at the end of cycle M+1 and captured at edge M+2.
- Empty-FIFO latency: push accepted in cycle N → read issued N+1 → `pop_valid=1` in cycle N+3.
- Steady state: one push and one pop per cycle with no bubbles once `ob_cnt=2`.
- Simultaneous push and pop when full (`count=DEPTH+2`):
  - The pop succeeds.
  - The push is refused that cycle (`mem_cnt=DEPTH`).
  - A read issues in the same cycle and frees a slot, so `push_ready=1` the next cycle.
- Simultaneous push and pop when empty: the pop is impossible (`pop_valid=0`); the push is accepted.
- Macro `dout1` is X after the hold window; the controller samples it only at the capture edge.

## Test plan
- **Reset values:** assert `rst` 2 cycles, release → `push_ready=1`, `pop_valid=0`, `count=0`, `csb0=csb1=1`.
- **Single word:** push 0x15A5A in cycle 0 → `csb0=0`, `addr0=0` in cycle 0; `csb1=0`, `addr1=0` in cycle 1; `pop_valid=1`, `pop_data=0x15A5A` in cycle 3; pop → `count=0`.
- **Fill to full:** push 34 words 0..33 with `pop_ready=0` → `push_ready` drops after word 33, `count=34`. Drain → data 0..33 in order, `pop_valid` continuous.
- **Streaming and wrap:** push and pop every cycle for 100 words (values i*3) → no bubbles after the first 3 cycles; `addr0`/`addr1` wrap 31→0 and data stays ordered.
- **Full with simultaneous push and pop:** at `count=34`, `push_valid=pop_ready=1` → pop fires, push refused; push accepted the next cycle; `count` returns to 34.
- **Reset mid-operation:** `rst` for 1 cycle with `rd_pend=1` and `ob_cnt=2` → next cycle `count=0`, `pop_valid=0`. A following push of 0x3FFFFF pops as 0x3FFFFF, not stale data.
